// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// A store to TXDATA queues a byte in a small FIFO. A two-process FSM drains
// the FIFO onto tx, one frame at a time. Register reads are combinational so
// a single-cycle load needs no stall.
module mmio_uart_tx #(
    parameter logic [31:0] BASE        = 32'hFFFF_FF00,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic [15:0]   div_reg;

    // Transmit engine state
    state_t        state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bitcnt_reg, bitcnt_next;
    logic [15:0]   baud_reg, baud_next;

    logic [1:0]    offset;
    logic          push, push_ok, pop;
    logic          empty, full, busy;
    logic          status_wr, div_wr;
    logic [3:0]    count_field;
    logic [31:0]   status_word;
    logic          unused_bits;

    // Address bits [1:0] and the upper store-data half never affect state.
    assign unused_bits = ^{a[1:0], wd[31:16]};

    assign hit       = (a[31:4] == BASE[31:4]);
    assign offset    = a[3:2];
    assign push      = we & hit & (offset == 2'd0);
    assign status_wr = we & hit & (offset == 2'd1);
    assign div_wr    = we & hit & (offset == 2'd2);

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign busy  = (state_reg != IDLE);

    // A push into a full FIFO still lands when the FSM pops on the same edge.
    assign push_ok = push & (~full | pop);

    assign count_field = 4'(count_reg);
    assign status_word = {22'b0, overflow_reg, busy, count_field, 2'b00, full, empty};

    // Combinational register read, zero when the address misses this block.
    always_comb begin
        rd = 32'h0;
        if (hit) begin
            case (offset)
                2'd1:    rd = status_word;
                2'd2:    rd = {16'h0, div_reg};
                default: rd = 32'h0;
            endcase
        end
    end

    // FIFO data array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wd[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (push & ~push_ok) begin
                overflow_reg <= 1'b1;
            end else if (status_wr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Bit-period divisor; zero would stall the baud counter, so it becomes 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= DEFAULT_DIV;
        end else if (div_wr) begin
            div_reg <= (wd[15:0] == 16'h0) ? 16'h1 : wd[15:0];
        end
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            shift_reg  <= 8'h0;
            bitcnt_reg <= 3'd0;
            baud_reg   <= 16'h0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            bitcnt_reg <= bitcnt_next;
            baud_reg   <= baud_next;
        end
    end

    // Next-state logic: each bit lasts div_reg clocks, the counter reloads at
    // every bit boundary so divisor changes apply from the next bit on.
    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        bitcnt_next = bitcnt_reg;
        baud_next   = baud_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_next  = mem[rd_ptr_reg];
                    bitcnt_next = 3'd0;
                    baud_next   = div_reg - 16'd1;
                    state_next  = START;
                end
            end
            START: begin
                if (baud_reg == 16'h0) begin
                    baud_next  = div_reg - 16'd1;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            DATA: begin
                if (baud_reg == 16'h0) begin
                    baud_next  = div_reg - 16'd1;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bitcnt_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bitcnt_next = bitcnt_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            STOP: begin
                if (baud_reg == 16'h0) begin
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is a pure decode of registered state, so reset forces idle-high at once.
    always_comb begin
        case (state_reg)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO
// overflow/wrap, divisor corner cases and asynchronous reset mid-frame.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_DV = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a, wd, rd;
    logic        hit, tx;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Serial monitor (bit period of 4 clocks) collecting received bytes.
    logic [7:0] rxq [$];
    logic [7:0] mon_byte;
    bit         mon_en    = 1'b0;
    int         frame_err = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(.BASE(BASE), .DEPTH(4), .DEFAULT_DIV(16'd16)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
        .rd(rd), .hit(hit), .tx(tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the store happens at the following posedge.
    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        we = 1'b1; a = adr; wd = d;
        @(negedge clk);
        we = 1'b0; a = 32'h0; wd = 32'h0;
    endtask

    task automatic rdr(input logic [31:0] adr, output logic [31:0] v);
        a = adr;
        #1;
        v = rd;
        a = 32'h0;
    endtask

    // Samples each bit in the middle of its 4-clock period.
    always begin
        @(negedge clk);
        if (mon_en && reset === 1'b1 && tx === 1'b0) begin
            repeat (6) @(negedge clk);
            mon_byte[0] = tx;
            for (int j = 1; j < 8; j++) begin
                repeat (4) @(negedge clk);
                mon_byte[j] = tx;
            end
            repeat (4) @(negedge clk);
            if (tx !== 1'b1) frame_err++;
            rxq.push_back(mon_byte);
        end
    end

    initial begin
        logic [31:0] st;
        logic [9:0]  frame;
        logic [7:0]  exp3 [5];
        logic [7:0]  exp4 [6];
        int          bad;

        exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

        // 1: reset values
        reset = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'h1);
        rdr(A_ST, st); chk("rst_status", st, 32'h1);
        rdr(A_DV, st); chk("rst_div", st, 32'd16);
        reset = 1'b1;
        @(negedge clk);

        // 2: single byte at divisor 4
        wr(A_DV, 32'd4);
        rdr(A_DV, st); chk("t2_div", st, 32'd4);
        wr(A_TX, 32'h0000_00A5);
        chk("t2_tx_before", {31'b0, tx}, 32'h1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("t2_tx%0d", i), {31'b0, tx}, {31'b0, frame[i/4]});
            if (i == 0 || i == 39) begin
                rdr(A_ST, st); chk($sformatf("t2_status%0d", i), st, 32'h101);
            end
        end
        @(negedge clk);
        chk("t2_tx_idle", {31'b0, tx}, 32'h1);
        rdr(A_ST, st); chk("t2_status_idle", st, 32'h1);

        // 3: fill and overflow
        mon_en = 1'b1;
        wr(A_TX, 32'h11); wr(A_TX, 32'h22); wr(A_TX, 32'h33);
        wr(A_TX, 32'h44); wr(A_TX, 32'h55); wr(A_TX, 32'h66);
        rdr(A_ST, st); chk("t3_status_ovf", st, 32'h342);
        wr(A_ST, 32'h0);
        rdr(A_ST, st); chk("t3_status_clr", st, 32'h142);
        for (int i = 0; i < 600 && rxq.size() < 5; i++) @(negedge clk);
        chk("t3_rx_count", rxq.size(), 32'd5);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            chk($sformatf("t3_rx%0d", i), {24'b0, rxq[i]}, {24'b0, exp3[i]});
        repeat (4) @(negedge clk);
        chk("t3_rx_count_final", rxq.size(), 32'd5);
        rdr(A_ST, st); chk("t3_status_end", st, 32'h1);
        rxq.delete();

        // 4: push while full on the edge the FSM pops
        wr(A_TX, 32'hA1); wr(A_TX, 32'hA2); wr(A_TX, 32'hA3);
        wr(A_TX, 32'hA4); wr(A_TX, 32'hA5);
        repeat (37) @(negedge clk);
        rdr(A_ST, st); chk("t4_status_full_idle", st, 32'h042);
        wr(A_TX, 32'hA6);
        rdr(A_ST, st); chk("t4_status_after", st, 32'h142);
        for (int i = 0; i < 800 && rxq.size() < 6; i++) @(negedge clk);
        chk("t4_rx_count", rxq.size(), 32'd6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            chk($sformatf("t4_rx%0d", i), {24'b0, rxq[i]}, {24'b0, exp4[i]});
        chk("t4_frame_err", frame_err, 32'd0);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        rxq.delete();

        // 5a: divisor 0 stores 1, 10-clock frame
        wr(A_DV, 32'h0);
        rdr(A_DV, st); chk("t5_div_zero", st, 32'd1);
        wr(A_TX, 32'h3C);
        chk("t5_tx_before", {31'b0, tx}, 32'h1);
        frame = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t5_tx%0d", i), {31'b0, tx}, {31'b0, frame[i]});
        end
        @(negedge clk);
        chk("t5_tx_idle", {31'b0, tx}, 32'h1);
        rdr(A_ST, st); chk("t5_status_idle", st, 32'h1);

        // 5b: divisor 4 -> 8 during data bit 0
        wr(A_DV, 32'd4);
        wr(A_TX, 32'h55);
        repeat (5) @(negedge clk);
        chk("t5b_bit0_a", {31'b0, tx}, 32'h1);
        wr(A_DV, 32'd8);
        chk("t5b_bit0_b", {31'b0, tx}, 32'h1);
        for (int i = 7; i <= 17; i++) begin
            @(negedge clk);
            chk($sformatf("t5b_tx%0d", i), {31'b0, tx},
                (i >= 9 && i <= 16) ? 32'h0 : 32'h1);
        end
        for (int i = 0; i < 200; i++) begin
            rdr(A_ST, st);
            if (st[8] == 1'b0) break;
            @(negedge clk);
        end
        rdr(A_ST, st); chk("t5b_status_end", st, 32'h1);

        // 6: reset during data bit 3
        wr(A_DV, 32'd4);
        wr(A_TX, 32'h00); wr(A_TX, 32'hB2); wr(A_TX, 32'hB3);
        repeat (16) @(negedge clk);
        chk("t6_tx_bit3", {31'b0, tx}, 32'h0);
        reset = 1'b0;
        #1;
        chk("t6_tx_in_reset", {31'b0, tx}, 32'h1);
        rdr(A_ST, st); chk("t6_status_in_reset", st, 32'h1);
        rdr(A_DV, st); chk("t6_div_in_reset", st, 32'd16);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("t6_no_residual", bad, 32'd0);
        rdr(A_ST, st); chk("t6_status_after", st, 32'h1);

        // Decode: misses, partial decode and reserved offset
        a = 32'h1000_0008; #1;
        chk("dec_miss_hit", {31'b0, hit}, 32'h0);
        chk("dec_miss_rd", rd, 32'h0);
        a = 32'h0;
        wr(32'h1000_0008, 32'd5);
        rdr(A_DV, st); chk("dec_miss_nowrite", st, 32'd16);
        a = BASE + 32'h6; #1;
        chk("dec_partial_hit", {31'b0, hit}, 32'h1);
        chk("dec_partial_rd", rd, 32'h1);
        a = 32'h0;
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rdr(BASE + 32'hC, st); chk("dec_reserved", st, 32'h0);
        rdr(A_TX, st); chk("dec_txdata_rd", st, 32'h0);
        rdr(A_DV, st); chk("dec_reserved_nowrite", st, 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
